// File: rtl/onewire_temp_responder.sv
// DS18B20-style 1-Wire slave: reset/presence, Skip ROM, Convert T and Read Scratchpad.
// Optional macro ONEWIRE_FULL_SCRATCHPAD_EN serves all 9 scratchpad bytes with a serial CRC8.
module onewire_temp_responder #(
    parameter int RST_MIN     = 400,
    parameter int PRES_WAIT   = 30,
    parameter int PRES_LEN    = 120,
    parameter int SAMPLE_AT   = 30,
    parameter int READ_HOLD   = 30,
    parameter int CONV_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dq_in,
    output logic        dq_oe,
    input  logic [15:0] temp_in,
    output logic [7:0]  cmd_byte,
    output logic        cmd_valid,
    output logic        conv_busy
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_RST_LOW    = 4'd1;
    localparam logic [3:0] S_PRES_WAIT  = 4'd2;
    localparam logic [3:0] S_PRES_DRIVE = 4'd3;
    localparam logic [3:0] S_ROM_CMD    = 4'd4;
    localparam logic [3:0] S_FUNC_CMD   = 4'd5;
    localparam logic [3:0] S_CONV_POLL  = 4'd6;
    localparam logic [3:0] S_TX_BYTES   = 4'd7;
    localparam logic [3:0] S_WAIT_RESET = 4'd8;

    localparam logic [15:0] L_RST_MIN    = 16'(RST_MIN);
    localparam logic [15:0] L_RST_MIN_M1 = 16'(RST_MIN - 1);
    localparam logic [15:0] L_PW_M1      = 16'(PRES_WAIT - 1);
    localparam logic [15:0] L_PL_M1      = 16'(PRES_LEN - 1);
    localparam logic [15:0] L_SAMPLE     = 16'(SAMPLE_AT);
    localparam logic [15:0] L_READ_HOLD  = 16'(READ_HOLD);
    localparam logic [15:0] L_SLOT_MIN   = 16'((SAMPLE_AT > READ_HOLD) ? SAMPLE_AT : READ_HOLD);
    localparam logic [15:0] L_CONV       = 16'(CONV_CYCLES);

`ifdef ONEWIRE_FULL_SCRATCHPAD_EN
    localparam int TX_W    = 64;
    localparam int TX_BITS = 72;
`else
    localparam int TX_W    = 16;
    localparam int TX_BITS = 16;
`endif
    localparam logic [6:0] L_TX_LAST = 7'(TX_BITS - 1);

    logic            r_dq_s1, r_dq_s2, r_dq_prev;
    logic [15:0]     r_low_cnt;
    logic [3:0]      r_state;
    logic [15:0]     r_tcnt;
    logic            r_slot_act;
    logic [15:0]     r_slot_cnt;
    logic            r_rd_hold;
    logic [7:0]      r_rx;
    logic [6:0]      r_bitcnt;
    logic [TX_W-1:0] r_tx;
    logic [15:0]     r_conv_cnt;
    logic [15:0]     r_scratch;
`ifdef ONEWIRE_FULL_SCRATCHPAD_EN
    logic [7:0]      r_crc;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        return fb ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    endfunction
`endif

    logic       w_fall, w_rise, w_rst_hit;
    logic       w_wr_state, w_rd_state, w_slot_start;
    logic       w_tx_bit, w_rd_zero, w_sample, w_byte_done;
    logic [7:0] w_rx_byte;

    assign w_fall     = r_dq_prev & ~r_dq_s2;
    assign w_rise     = ~r_dq_prev & r_dq_s2;
    assign w_rst_hit  = ~r_dq_s2 && (r_low_cnt == L_RST_MIN_M1);
    assign w_wr_state = (r_state == S_ROM_CMD) || (r_state == S_FUNC_CMD);
    assign w_rd_state = (r_state == S_CONV_POLL) || (r_state == S_TX_BYTES);
    assign w_slot_start = w_fall & ~r_slot_act & (w_wr_state | w_rd_state);

    // Bit presented on a read slot: busy flag while polling, else the scratchpad/CRC stream
    always_comb begin
        w_tx_bit = 1'b1;
        if (r_state == S_CONV_POLL) begin
            w_tx_bit = ~conv_busy;
        end else if (r_state == S_TX_BYTES) begin
`ifdef ONEWIRE_FULL_SCRATCHPAD_EN
            w_tx_bit = (r_bitcnt < 7'd64) ? r_tx[0] : r_crc[0];
`else
            w_tx_bit = r_tx[0];
`endif
        end
    end

    assign w_rd_zero   = w_slot_start & w_rd_state & ~w_tx_bit;
    assign w_sample    = r_slot_act & w_wr_state & (r_slot_cnt == L_SAMPLE);
    assign w_rx_byte   = {r_dq_s2, r_rx[7:1]};
    assign w_byte_done = w_sample & (r_bitcnt == 7'd7);
    assign dq_oe       = (r_state == S_PRES_DRIVE) | r_rd_hold | w_rd_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dq_s1   <= 1'b1;
            r_dq_s2   <= 1'b1;
            r_dq_prev <= 1'b1;
            r_low_cnt <= 16'd0;
        end else begin
            r_dq_s1   <= dq_in;
            r_dq_s2   <= r_dq_s1;
            r_dq_prev <= r_dq_s2;
            if (r_dq_s2)
                r_low_cnt <= 16'd0;
            else if (r_low_cnt != L_RST_MIN)
                r_low_cnt <= r_low_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tcnt     <= 16'd0;
            r_slot_act <= 1'b0;
            r_slot_cnt <= 16'd0;
            r_rd_hold  <= 1'b0;
            r_rx       <= 8'd0;
            r_bitcnt   <= 7'd0;
            r_tx       <= '0;
            r_conv_cnt <= 16'd0;
            r_scratch  <= 16'h0550;
            cmd_byte   <= 8'h00;
            cmd_valid  <= 1'b0;
            conv_busy  <= 1'b0;
`ifdef ONEWIRE_FULL_SCRATCHPAD_EN
            r_crc      <= 8'd0;
`endif
        end else begin
            cmd_valid <= 1'b0;

            if (conv_busy) begin
                if (r_conv_cnt == 16'd1) begin
                    conv_busy  <= 1'b0;
                    r_conv_cnt <= 16'd0;
                    r_scratch  <= temp_in;
                end else begin
                    r_conv_cnt <= r_conv_cnt - 16'd1;
                end
            end

            // Slot stays armed until sampled and the bus is back high
            if (w_slot_start) begin
                r_slot_act <= 1'b1;
                r_slot_cnt <= 16'd1;
            end else if (r_slot_act) begin
                if (r_dq_s2 && (r_slot_cnt > L_SLOT_MIN))
                    r_slot_act <= 1'b0;
                if (r_slot_cnt != 16'hFFFF)
                    r_slot_cnt <= r_slot_cnt + 16'd1;
            end

            if (w_rd_zero)
                r_rd_hold <= 1'b1;
            else if (r_slot_cnt >= L_READ_HOLD)
                r_rd_hold <= 1'b0;

            case (r_state)
                S_IDLE: ;
                S_RST_LOW: begin
                    if (w_rise) begin
                        r_state <= S_PRES_WAIT;
                        r_tcnt  <= 16'd0;
                    end
                end
                S_PRES_WAIT: begin
                    if (r_tcnt == L_PW_M1) begin
                        r_state <= S_PRES_DRIVE;
                        r_tcnt  <= 16'd0;
                    end else begin
                        r_tcnt <= r_tcnt + 16'd1;
                    end
                end
                S_PRES_DRIVE: begin
                    if (r_tcnt == L_PL_M1) begin
                        r_state  <= S_ROM_CMD;
                        r_tcnt   <= 16'd0;
                        r_bitcnt <= 7'd0;
                    end else begin
                        r_tcnt <= r_tcnt + 16'd1;
                    end
                end
                S_ROM_CMD: begin
                    if (w_sample) begin
                        r_rx     <= w_rx_byte;
                        r_bitcnt <= r_bitcnt + 7'd1;
                    end
                    if (w_byte_done) begin
                        r_bitcnt <= 7'd0;
                        r_state  <= (w_rx_byte == 8'hCC) ? S_FUNC_CMD : S_WAIT_RESET;
                    end
                end
                S_FUNC_CMD: begin
                    if (w_sample) begin
                        r_rx     <= w_rx_byte;
                        r_bitcnt <= r_bitcnt + 7'd1;
                    end
                    if (w_byte_done) begin
                        r_bitcnt  <= 7'd0;
                        cmd_byte  <= w_rx_byte;
                        cmd_valid <= 1'b1;
                        case (w_rx_byte)
                            8'h44: begin
                                conv_busy  <= 1'b1;
                                r_conv_cnt <= L_CONV;
                                r_state    <= S_CONV_POLL;
                            end
                            8'hBE: begin
`ifdef ONEWIRE_FULL_SCRATCHPAD_EN
                                r_tx  <= {8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, r_scratch};
                                r_crc <= 8'd0;
`else
                                r_tx  <= r_scratch;
`endif
                                r_state <= S_TX_BYTES;
                            end
                            default: r_state <= S_WAIT_RESET;
                        endcase
                    end
                end
                S_CONV_POLL: ;
                S_TX_BYTES: begin
                    if (w_slot_start) begin
`ifdef ONEWIRE_FULL_SCRATCHPAD_EN
                        if (r_bitcnt < 7'd64)
                            r_crc <= crc8_step(r_crc, r_tx[0]);
                        else
                            r_crc <= r_crc >> 1;
`endif
                        r_tx     <= r_tx >> 1;
                        r_bitcnt <= r_bitcnt + 7'd1;
                        if (r_bitcnt == L_TX_LAST)
                            r_state <= S_WAIT_RESET;
                    end
                end
                S_WAIT_RESET: ;
                default: r_state <= S_IDLE;
            endcase

            // Bus reset wins over any state; conversion keeps running
            if (w_rst_hit) begin
                r_state    <= S_RST_LOW;
                r_slot_act <= 1'b0;
                r_rd_hold  <= 1'b0;
                r_bitcnt   <= 7'd0;
            end
        end
    end

endmodule

// File: tb/tb_onewire_temp_responder.sv
// Directed bench for onewire_temp_responder: a behavioural 1-Wire master on an open-drain bus.
module tb_onewire_temp_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_low;
    logic        dq_bus;
    logic        dq_oe;
    logic [15:0] temp_in;
    logic [7:0]  cmd_byte;
    logic        cmd_valid;
    logic        conv_busy;

    int n_cmp = 0;
    int n_err = 0;
    int n_valid = 0;
    int n_busy = 0;
    int n_oe = 0;

    assign dq_bus = ~(m_low | dq_oe);

    onewire_temp_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dq_in     (dq_bus),
        .dq_oe     (dq_oe),
        .temp_in   (temp_in),
        .cmd_byte  (cmd_byte),
        .cmd_valid (cmd_valid),
        .conv_busy (conv_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid) n_valid <= n_valid + 1;
        if (conv_busy) n_busy <= n_busy + 1;
        if (dq_oe)     n_oe <= n_oe + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hw_reset();
        rst_n = 1'b0;
        m_low = 1'b0;
        tick(4);
        rst_n = 1'b1;
        tick(4);
    endtask

    // Master reset pulse; returns cycles from release to presence start and presence length
    task automatic bus_reset(output int st, output int ln);
        m_low = 1'b1;
        tick(480);
        m_low = 1'b0;
        st = -1;
        ln = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (dq_oe) begin st = i; break; end
        end
        if (st > 0) begin
            ln = 1;
            for (int i = 0; i < 300; i++) begin
                @(posedge clk); #1;
                if (!dq_oe) break;
                ln++;
            end
        end
        tick(10);
    endtask

    task automatic write_byte(input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            m_low = 1'b1;
            tick(d[i] ? 5 : 60);
            m_low = 1'b0;
            tick(d[i] ? 65 : 10);
        end
    endtask

    task automatic read_bit(output logic b);
        m_low = 1'b1;
        tick(2);
        m_low = 1'b0;
        tick(10);
        b = dq_bus;
        tick(58);
    endtask

    task automatic read_byte(output logic [7:0] d);
        logic b;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d[i] = b;
        end
    endtask

    task automatic wait_not_busy();
        for (int i = 0; i < 2000; i++) begin
            if (!conv_busy) break;
            tick(1);
        end
        n_cmp++;
        if (conv_busy !== 1'b0) begin n_err++; $display("FAIL conv_timeout: busy=%0b want 0", conv_busy); end
    endtask

    task automatic test_reset();
        hw_reset();
        n_cmp++; if (dq_oe !== 1'b0) begin n_err++; $display("FAIL rst_dq_oe: got %0b want 0", dq_oe); end
        n_cmp++; if (cmd_byte !== 8'h00) begin n_err++; $display("FAIL rst_cmd_byte: got %0h want 00", cmd_byte); end
        n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL rst_cmd_valid: got %0b want 0", cmd_valid); end
        n_cmp++; if (conv_busy !== 1'b0) begin n_err++; $display("FAIL rst_conv_busy: got %0b want 0", conv_busy); end
    endtask

    task automatic test_default_scratch();
        int st, ln;
        logic [7:0] d;
`ifdef ONEWIRE_FULL_SCRATCHPAD_EN
        logic [7:0] exp9 [0:8];
        exp9 = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};
`endif
        hw_reset();
        bus_reset(st, ln);
        write_byte(8'hCC);
        write_byte(8'hBE);
`ifdef ONEWIRE_FULL_SCRATCHPAD_EN
        for (int i = 0; i < 9; i++) begin
            read_byte(d);
            n_cmp++; if (d !== exp9[i]) begin n_err++; $display("FAIL full_scratch_byte%0d: got %0h want %0h", i, d, exp9[i]); end
        end
`else
        read_byte(d);
        n_cmp++; if (d !== 8'h50) begin n_err++; $display("FAIL dflt_scratch_lsb: got %0h want 50", d); end
        read_byte(d);
        n_cmp++; if (d !== 8'h05) begin n_err++; $display("FAIL dflt_scratch_msb: got %0h want 05", d); end
`endif
    endtask

    task automatic test_presence_and_convert();
        int st, ln, oe0, nv0, nb0;
        logic b;
        hw_reset();
        oe0 = n_oe;
        m_low = 1'b1;
        tick(300);
        m_low = 1'b0;
        tick(300);
        n_cmp++; if (n_oe - oe0 !== 0) begin n_err++; $display("FAIL short_low_presence: oe cycles %0d want 0", n_oe - oe0); end
        bus_reset(st, ln);
        n_cmp++; if (st < 32 || st > 34) begin n_err++; $display("FAIL pres_start: got %0d want 32..34", st); end
        n_cmp++; if (ln !== 120) begin n_err++; $display("FAIL pres_len: got %0d want 120", ln); end
        nv0 = n_valid;
        nb0 = n_busy;
        write_byte(8'hCC);
        write_byte(8'h44);
        n_cmp++; if (cmd_byte !== 8'h44) begin n_err++; $display("FAIL conv_cmd_byte: got %0h want 44", cmd_byte); end
        n_cmp++; if (conv_busy !== 1'b1) begin n_err++; $display("FAIL conv_busy_set: got %0b want 1", conv_busy); end
        for (int i = 0; i < 2; i++) begin
            read_bit(b);
            n_cmp++; if (b !== 1'b0) begin n_err++; $display("FAIL poll_busy%0d: got %0b want 0", i, b); end
        end
        wait_not_busy();
        n_cmp++; if (n_valid - nv0 !== 1) begin n_err++; $display("FAIL conv_valid_pulses: got %0d want 1", n_valid - nv0); end
        n_cmp++; if (n_busy - nb0 !== 1000) begin n_err++; $display("FAIL conv_busy_len: got %0d want 1000", n_busy - nb0); end
        read_bit(b);
        n_cmp++; if (b !== 1'b1) begin n_err++; $display("FAIL poll_done: got %0b want 1", b); end
    endtask

    task automatic test_temp_read();
        int st, ln;
        logic [7:0] d;
        temp_in = 16'h0191;
        bus_reset(st, ln);
        write_byte(8'hCC);
        write_byte(8'h44);
        wait_not_busy();
        temp_in = 16'h0000;
        bus_reset(st, ln);
        write_byte(8'hCC);
        write_byte(8'hBE);
        n_cmp++; if (cmd_byte !== 8'hBE) begin n_err++; $display("FAIL read_cmd_byte: got %0h want BE", cmd_byte); end
        read_byte(d);
        n_cmp++; if (d !== 8'h91) begin n_err++; $display("FAIL temp_lsb: got %0h want 91", d); end
        read_byte(d);
        n_cmp++; if (d !== 8'h01) begin n_err++; $display("FAIL temp_msb: got %0h want 01", d); end
        read_byte(d);
`ifdef ONEWIRE_FULL_SCRATCHPAD_EN
        n_cmp++; if (d !== 8'h4B) begin n_err++; $display("FAIL third_byte: got %0h want 4B", d); end
`else
        n_cmp++; if (d !== 8'hFF) begin n_err++; $display("FAIL third_byte: got %0h want FF", d); end
`endif
    endtask

    task automatic test_bad_rom();
        int st, ln, oe0, nv0;
        logic [7:0] d0, d1;
        bus_reset(st, ln);
        write_byte(8'h55);
        oe0 = n_oe;
        nv0 = n_valid;
        read_byte(d0);
        read_byte(d1);
        n_cmp++; if ({d1, d0} !== 16'hFFFF) begin n_err++; $display("FAIL bad_rom_data: got %0h want FFFF", {d1, d0}); end
        n_cmp++; if (n_oe - oe0 !== 0) begin n_err++; $display("FAIL bad_rom_oe: oe cycles %0d want 0", n_oe - oe0); end
        n_cmp++; if (n_valid - nv0 !== 0) begin n_err++; $display("FAIL bad_rom_valid: got %0d want 0", n_valid - nv0); end
        bus_reset(st, ln);
        n_cmp++; if (st < 32 || st > 34) begin n_err++; $display("FAIL bad_rom_pres_start: got %0d want 32..34", st); end
        n_cmp++; if (ln !== 120) begin n_err++; $display("FAIL bad_rom_pres_len: got %0d want 120", ln); end
    endtask

    task automatic test_abort_mid_read();
        int st, ln;
        logic [4:0] part;
        logic b;
        logic [7:0] d;
        bus_reset(st, ln);
        write_byte(8'hCC);
        write_byte(8'hBE);
        for (int i = 0; i < 5; i++) begin
            read_bit(b);
            part[i] = b;
        end
        n_cmp++; if (part !== 5'h11) begin n_err++; $display("FAIL abort_partial: got %0h want 11", part); end
        bus_reset(st, ln);
        n_cmp++; if (st < 32 || st > 34) begin n_err++; $display("FAIL abort_pres_start: got %0d want 32..34", st); end
        n_cmp++; if (ln !== 120) begin n_err++; $display("FAIL abort_pres_len: got %0d want 120", ln); end
        write_byte(8'hCC);
        write_byte(8'hBE);
        read_byte(d);
        n_cmp++; if (d !== 8'h91) begin n_err++; $display("FAIL abort_re_lsb: got %0h want 91", d); end
        read_byte(d);
        n_cmp++; if (d !== 8'h01) begin n_err++; $display("FAIL abort_re_msb: got %0h want 01", d); end
    endtask

    initial begin
        rst_n   = 1'b0;
        m_low   = 1'b0;
        temp_in = 16'h0000;
        test_reset();
        test_default_scratch();
        test_presence_and_convert();
        test_temp_read();
        test_bad_rom();
        test_abort_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
